digit_serial_adder: RTL and testbench

- Parametrised, handshaked successor to the combinational ripple-carry adder.
- Adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first, reusing one DIGIT-bit adder slice across WIDTH/DIGIT cycles.
- Trades latency for area in arithmetic datapaths.
- Uses valid/ready handshakes on both input and output so it can sit between pipeline stages with backpressure.

---
 rtl/adder_pkg.sv | 29 ++
 rtl/digit_adder.sv | 35 +++
 rtl/digit_serial_adder.sv | 175 +++++++++++++++++
 tb/tb_digit_serial_adder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Purpose : shared types and sizing helpers for the digit-serial adder.
// Contents: state_t FSM encoding, digit_t default digit type,
//           num_digits()/cnt_width() elaboration-time sizing functions.
package adder_pkg;

    // Control states of the serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIGIT_DEFAULT = 4;

    // Digit type for the default configuration
    typedef logic [DIGIT_DEFAULT-1:0] digit_t;

    // Number of digits per operand; zero flags an illegal DIGIT of 0
    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit);
        return (digit == 0) ? 0 : width / digit;
    endfunction

    // Counter width for n digits, never below one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Purpose : combinational DIGIT-bit ripple-carry slice.
// Ports   : i_a, i_b   - digit operands
//           i_cin      - carry into bit 0
//           o_s_c      - digit sum
//           o_cout_c   - carry out of the top bit
//           o_cmsb_c   - carry into the top bit (for signed overflow)
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_s_c,
    output logic             o_cout_c,
    output logic             o_cmsb_c
);

    logic w_c;

    // Ripple the carry through the slice, tapping it ahead of the top bit
    always_comb begin
        w_c      = i_cin;
        o_cmsb_c = i_cin;
        o_s_c    = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                o_cmsb_c = w_c;
            end
            o_s_c[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout_c = w_c;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Purpose : WIDTH-bit adder processing DIGIT bits per clock, LSB digit
//           first, through one shared digit_adder slice, with valid/ready
//           handshakes on both sides.
// Ports   : clk, rst_n (async, active-low)
//           in_valid/in_ready, a, b, cin   - operand side
//           sub                            - subtract select (DIGIT_SERIAL_SUB_EN only)
//           out_valid/out_ready, s, cout, ovf - result side
// Config  : define DIGIT_SERIAL_SUB_EN to add the sub port (a + ~b + 1).
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DIGIT_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N     = num_digits(WIDTH, DIGIT);
    localparam int unsigned CNT_W = cnt_width(N);
    localparam int unsigned REM   = (DIGIT == 0) ? 1 : WIDTH % DIGIT;

    // Reject configurations where DIGIT does not tile WIDTH
    if (WIDTH < 2 || DIGIT == 0 || DIGIT > WIDTH || REM != 0) begin : g_bad_cfg
        $fatal(1, "digit_serial_adder: DIGIT (%0d) must divide WIDTH (%0d), WIDTH >= 2",
               DIGIT, WIDTH);
    end

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic [WIDTH-1:0]   w_sum_next;
    logic [DIGIT-1:0]   w_digit_s;
    logic               w_digit_cout;
    logic               w_digit_cmsb;

    // Operand conditioning at acceptance: subtraction becomes a + ~b + 1
`ifdef DIGIT_SERIAL_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    assign w_last = (r_cnt == CNT_W'(N - 1));

    // Shared digit slice works on the low digit of the shifting operands
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .i_a      (r_a[DIGIT-1:0]),
        .i_b      (r_b[DIGIT-1:0]),
        .i_cin    (r_carry),
        .o_s_c    (w_digit_s),
        .o_cout_c (w_digit_cout),
        .o_cmsb_c (w_digit_cmsb)
    );

    // New digit enters from the MSB side; after N shifts it sits in place
    if (N == 1) begin : g_single
        assign w_sum_next = w_digit_s;
    end else begin : g_multi
        assign w_sum_next = {w_digit_s, r_sum[WIDTH-1:DIGIT]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered handshake outputs follow the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == IDLE);
            r_out_valid <= (w_next_state == DONE);
        end
    end

    // Datapath: load on acceptance, shift one digit per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_digit_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_sum   <= w_sum_next;
            if (w_last) begin
                r_cout <= w_digit_cout;
                r_ovf  <= w_digit_cmsb ^ w_digit_cout;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Purpose : scoreboard bench for digit_serial_adder (WIDTH=8, DIGIT=2) plus
//           a WIDTH=32, DIGIT=32 single-digit instance.
// Config  : DIGIT_SERIAL_SUB_EN enables the subtract vectors.
module tb_digit_serial_adder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIGIT = 2;
    localparam int unsigned N     = WIDTH / DIGIT;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
`ifdef DIGIT_SERIAL_SUB_EN
    logic             sub_r     = 1'b0;
    logic             sub32     = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    logic             v32       = 1'b0;
    logic             rdy32;
    logic [31:0]      a32       = '0;
    logic [31:0]      b32       = '0;
    logic             cin32     = 1'b0;
    logic             ov32;
    logic             ordy32    = 1'b1;
    logic [31:0]      s32;
    logic             cout32;
    logic             ovf32;

    int               n_checks  = 0;
    int               n_fail    = 0;
    exp_t             sb[$];
    exp_t             mon_e;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef DIGIT_SERIAL_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    digit_serial_adder #(.WIDTH(32), .DIGIT(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v32),
        .in_ready  (rdy32),
        .a         (a32),
        .b         (b32),
        .cin       (cin32),
`ifdef DIGIT_SERIAL_SUB_EN
        .sub       (sub32),
`endif
        .out_valid (ov32),
        .out_ready (ordy32),
        .s         (s32),
        .cout      (cout32),
        .ovf       (ovf32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented-and-consumed result with the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: s=0x%0h with no pending expectation", s);
            end else begin
                mon_e = sb.pop_front();
                check("sum",  32'(s),    32'(mon_e.s));
                check("cout", 32'(cout), 32'(mon_e.cout));
                check("ovf",  32'(ovf),  32'(mon_e.ovf));
            end
        end
    end

    // One transaction from IDLE back to IDLE; hold = cycles of out_ready low
    task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                           input logic tsub, input logic [7:0] es, input logic ec,
                           input logic eo, input int hold);
        exp_t e;
        int   lat;
        a        = ta;
        b        = tb_v;
        cin      = tcin;
`ifdef DIGIT_SERIAL_SUB_EN
        sub_r    = tsub;
`endif
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        e.s    = es;
        e.cout = ec;
        e.ovf  = eo;
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble inputs after acceptance; they must be ignored
        in_valid  = 1'b0;
        a         = ~ta;
        b         = 8'h5A;
        cin       = ~tcin;
`ifdef DIGIT_SERIAL_SUB_EN
        sub_r     = ~tsub;
`endif
        out_ready = (hold == 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_run", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(N));
        for (int h = 0; h < hold; h++) begin
            check("hold_valid",    32'(out_valid), 32'd1);
            check("hold_s",        32'(s),         32'(es));
            check("hold_in_ready", 32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        check("done_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop",    32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready),  32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s",         32'(s),         32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Single-digit instance: one RUN cycle
        a32   = 32'hFFFF_FFFF;
        b32   = 32'hFFFF_FFFF;
        cin32 = 1'b1;
        v32   = 1'b1;
        check("w32_in_ready", 32'(rdy32), 32'd1);
        @(posedge clk); #1;
        v32 = 1'b0;
        check("w32_not_yet", 32'(ov32), 32'd0);
        @(posedge clk); #1;
        check("w32_valid", 32'(ov32),   32'd1);
        check("w32_s",     s32,         32'hFFFF_FFFF);
        check("w32_cout",  32'(cout32), 32'd1);
        check("w32_ovf",   32'(ovf32),  32'd0);
        @(posedge clk); #1;
        check("w32_drop",  32'(ov32),   32'd0);

        // Directed vectors: a, b, cin, sub, s, cout, ovf, hold
        run_txn(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_txn(8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 0);
        run_txn(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 6);
        run_txn(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        run_txn(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        run_txn(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);

        // Reset in the middle of RUN (digit 2 in progress)
        a        = 8'h55;
        b        = 8'h22;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_s",         32'(s),         32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd0);
        check("abort_cout",      32'(cout),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_recover_ready", 32'(in_ready),  32'd1);
        check("abort_no_result",     32'(out_valid), 32'd0);
        run_txn(8'h0A, 8'h05, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 0);

`ifdef DIGIT_SERIAL_SUB_EN
        run_txn(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        run_txn(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        run_txn(8'h30, 8'h10, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
